// File: rtl/pipelined_cla_subtractor_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor:
// default slice width, stage-count helper and per-stage control flags.
package pipelined_cla_subtractor_pkg;

  localparam int SLICE_W = 4;

  // Returns 0 when N is not a nonzero multiple of B so the top can refuse to elaborate.
  function automatic int stage_count(input int n, input int b);
    if (b > 0 && n >= b && (n % b) == 0) begin
      return n / b;
    end
    return 0;
  endfunction

  // Control part of a stage register; the data part (partial result and
  // remaining operand bits) changes width per stage and lives beside it.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sign_a;
    logic sign_b;
  } stage_flags_t;

endpackage

// File: rtl/pipelined_cla_subtractor_cla_slice.sv
// Combinational W-bit carry-lookahead slice: every carry is formed directly
// from generate/propagate terms and the slice carry-in.
module cla_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, flattened rather than rippled.
  always_comb begin
    logic prop;
    prop = 1'b0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Handshaked N-bit subtractor: Inp1 + ~Inp2 + ~Bin resolved B bits per stage
// with bubble-collapsing valid/ready flow control.
module pipelined_cla_subtractor
  import pipelined_cla_subtractor_pkg::*;
#(
  parameter int N = 16,
  parameter int B = SLICE_W
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [N-1:0] Inp1,
  input  logic [N-1:0] Inp2,
  input  logic         Bin,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [N-1:0] Result,
  output logic         Bout,
  output logic         Ovf
);

  localparam int STAGES = stage_count(N, B);

  if (STAGES < 1) begin : g_bad_width
    $error("pipelined_cla_subtractor: N must be a nonzero multiple of B");
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : stage_g
    localparam int IN_W  = N - gi * B;
    localparam int SUM_W = (gi + 1) * B;

    logic             in_valid;
    logic [IN_W-1:0]  in_a;
    logic [IN_W-1:0]  in_b;
    logic             in_carry;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [SUM_W-1:0] sum_next;
    logic [B-1:0]     slice_sum;
    logic             slice_cout;
    logic             load;
    stage_flags_t     flags_reg;
    logic [SUM_W-1:0] sum_reg;

    if (gi == 0) begin : g_head
      assign in_valid  = In_Valid;
      assign in_a      = Inp1;
      assign in_b      = ~Inp2;
      assign in_carry  = ~Bin;
      assign in_sign_a = Inp1[N-1];
      assign in_sign_b = Inp2[N-1];
      assign sum_next  = slice_sum;
    end else begin : g_body
      assign in_valid  = stage_g[gi-1].flags_reg.valid;
      assign in_a      = stage_g[gi-1].g_fwd.rem_a_reg;
      assign in_b      = stage_g[gi-1].g_fwd.rem_b_reg;
      assign in_carry  = stage_g[gi-1].flags_reg.carry;
      assign in_sign_a = stage_g[gi-1].flags_reg.sign_a;
      assign in_sign_b = stage_g[gi-1].flags_reg.sign_b;
      assign sum_next  = {slice_sum, stage_g[gi-1].sum_reg};
    end

    // A stage may take new data when empty or when its occupant moves on this cycle.
    if (gi == STAGES - 1) begin : g_tail_load
      assign load = !flags_reg.valid || Out_Ready;
    end else begin : g_mid_load
      assign load = !flags_reg.valid || stage_g[gi+1].load;
    end

    cla_slice #(.W(B)) u_slice (
      .a    (in_a[B-1:0]),
      .b    (in_b[B-1:0]),
      .cin  (in_carry),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        flags_reg <= '0;
        sum_reg   <= '0;
      end else if (load) begin
        flags_reg.valid <= in_valid;
        if (in_valid) begin
          flags_reg.carry  <= slice_cout;
          flags_reg.sign_a <= in_sign_a;
          flags_reg.sign_b <= in_sign_b;
          sum_reg          <= sum_next;
        end
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [IN_W-B-1:0] rem_a_reg;
      logic [IN_W-B-1:0] rem_b_reg;

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          rem_a_reg <= '0;
          rem_b_reg <= '0;
        end else if (load && in_valid) begin
          rem_a_reg <= in_a[IN_W-1:B];
          rem_b_reg <= in_b[IN_W-1:B];
        end
      end
    end
  end

  assign In_Ready  = stage_g[0].load;
  assign Out_Valid = stage_g[STAGES-1].flags_reg.valid;
  assign Result    = stage_g[STAGES-1].sum_reg;

  // Carry resets to 0, so the borrow is qualified by valid to read 0 out of reset.
  assign Bout = stage_g[STAGES-1].flags_reg.valid & ~stage_g[STAGES-1].flags_reg.carry;
  assign Ovf  = (stage_g[STAGES-1].flags_reg.sign_a ^ stage_g[STAGES-1].flags_reg.sign_b)
              & (Result[N-1] ^ stage_g[STAGES-1].flags_reg.sign_a);

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Directed bench for pipelined_cla_subtractor with an in-order scoreboard.
module tb_pipelined_cla_subtractor;

  localparam int N      = 16;
  localparam int STAGES = 4;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         In_Valid;
  logic         In_Ready;
  logic [N-1:0] Inp1;
  logic [N-1:0] Inp2;
  logic         Bin;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [N-1:0] Result;
  logic         Bout;
  logic         Ovf;

  typedef struct {
    logic [N-1:0] result;
    logic         bout;
    logic         ovf;
    int           acc_cyc;
    bit           lat_chk;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   popped = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  pipelined_cla_subtractor #(.N(N), .B(4)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Inp1      (Inp1),
    .Inp2      (Inp2),
    .Bin       (Bin),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result),
    .Bout      (Bout),
    .Ovf       (Ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
    exp_t e;
    logic [N:0] d;
    d = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
    e.result  = d[N-1:0];
    e.bout    = d[N];
    e.ovf     = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    e.acc_cyc = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  // Scoreboard consumer: every delivered beat is compared against the oldest expectation.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n === 1'b1 && Out_Valid === 1'b1 && Out_Ready === 1'b1) begin
      tests++;
      assert (sb_q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_out: observed result=0x%04h expected no output", Result);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("result", 32'(Result), 32'(e.result));
        check("bout", 32'(Bout), 32'(e.bout));
        check("ovf", 32'(Ovf), 32'(e.ovf));
        if (e.lat_chk) check("latency", 32'(cyc - e.acc_cyc), 32'(STAGES - 1));
        popped++;
        $display("[TB] out #%0d result=0x%04h bout=%0b ovf=%0b (exp 0x%04h %0b %0b)",
                 popped, Result, Bout, Ovf, e.result, e.bout, e.ovf);
      end
    end
  end

  // Entered and left just after a rising edge; In_Valid stays high on return.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, input bit lat);
    exp_t e;
    bit   done;
    done     = 1'b0;
    In_Valid = 1'b1;
    Inp1     = a;
    Inp2     = b;
    Bin      = bi;
    for (int w = 0; w < 50 && !done; w++) begin
      @(negedge Clk);
      if (In_Ready) begin
        e         = model(a, b, bi);
        e.acc_cyc = cyc + 1;
        e.lat_chk = lat;
        sb_q.push_back(e);
        done = 1'b1;
        $display("[TB] in a=0x%04h b=0x%04h bin=%0b", a, b, bi);
      end
      @(posedge Clk);
      #1;
    end
    tests++;
    assert (done) else begin
      fails++;
      $error("FAIL accept_timeout: observed In_Ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic drain();
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    for (int w = 0; w < 30 && sb_q.size() != 0; w++) @(negedge Clk);
    @(negedge Clk);
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    int  stall;
    int  gap_chk;
    bit  released;

    Rst_n     = 1'b0;
    In_Valid  = 1'b0;
    Inp1      = '0;
    Inp2      = '0;
    Bin       = 1'b0;
    Out_Ready = 1'b1;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_out_valid", 32'(Out_Valid), 32'd0);
    check("rst_result", 32'(Result), 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    check("rst_in_ready", 32'(In_Ready), 32'd1);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    send(16'h0005, 16'h0003, 1'b0, 1'b1); drain();
    send(16'h0000, 16'h0001, 1'b0, 1'b1); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
    send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1); drain();
    send(16'h1234, 16'h1234, 1'b1, 1'b1); drain();

    // Back-to-back random beats at full rate.
    for (int i = 0; i < 12; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    // Backpressure: consumer holds off until the first result has waited 5 cycles.
    acc       = 0;
    stall     = 0;
    gap_chk   = 0;
    released  = 1'b0;
    for (int c = 0; c < 60 && gap_chk < 6; c++) begin
      In_Valid  = (acc < 6);
      Inp1      = 16'(10 + acc);
      Inp2      = 16'h0001;
      Bin       = 1'b0;
      Out_Ready = released;
      @(negedge Clk);
      if (released) begin
        check("no_gap", 32'(Out_Valid), 32'd1);
        gap_chk++;
      end else if (Out_Valid) begin
        check("stall_result", 32'(Result), 32'h0009);
        check("stall_bout", 32'(Bout), 32'd0);
        check("stall_in_ready", 32'(In_Ready), 32'd0);
        stall++;
        if (stall == 5) released = 1'b1;
      end else begin
        check("fill_in_ready", 32'(In_Ready), 32'd1);
      end
      if (In_Valid && In_Ready) begin
        sb_q.push_back(model(Inp1, Inp2, Bin));
        $display("[TB] in a=0x%04h b=0x%04h bin=%0b", Inp1, Inp2, Bin);
        acc++;
      end
      @(posedge Clk);
      #1;
    end
    check("bp_beats_accepted", 32'(acc), 32'd6);
    drain();

    // Reset with three beats in flight and the oldest waiting at the output.
    Out_Ready = 1'b0;
    send(16'h8000, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b0);
    send(16'h4321, 16'h1234, 1'b1, 1'b0);
    In_Valid = 1'b0;
    for (int w = 0; w < 20 && Out_Valid !== 1'b1; w++) @(negedge Clk);
    check("flight_out_valid", 32'(Out_Valid), 32'd1);
    check("flight_result", 32'(Result), 32'h7FFF);
    check("flight_ovf", 32'(Ovf), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(Out_Valid), 32'd0);
    check("async_rst_result", 32'(Result), 32'd0);
    check("async_rst_bout", 32'(Bout), 32'd0);
    check("async_rst_ovf", 32'(Ovf), 32'd0);
    check("async_rst_in_ready", 32'(In_Ready), 32'd1);
    sb_q.delete();
    @(posedge Clk);
    #2;
    Rst_n     = 1'b1;
    Out_Ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      check("post_rst_quiet", 32'(Out_Valid), 32'd0);
    end
    @(posedge Clk);
    #1;
    send(16'h0010, 16'h0001, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
